// File: rtl/display_pkg.sv
// Shared types and constants for the mic-to-OLED display mode controller.
package display_pkg;

  localparam int MODE_W    = 2;
  localparam int SAMPLE_W  = 12;
  localparam int MIDSCALE  = 2048;
  localparam int LEVEL_W   = 4;
  localparam int GAIN_MAX  = 7;
  localparam int GAIN_W    = 3;
  localparam int MAG_W     = 11;
  localparam int SCALED_W  = 18;
  localparam int LED_W     = 16;
  localparam int NUM_BTN   = 5;

  // Button indices, highest action priority first.
  localparam int BTN_C = 0;
  localparam int BTN_R = 1;
  localparam int BTN_L = 2;
  localparam int BTN_U = 3;
  localparam int BTN_D = 4;

  typedef enum logic [MODE_W-1:0] {
    IDLE   = 2'd0,
    VOLUME = 2'd1,
    WAVE   = 2'd2,
    MENU   = 2'd3
  } mode_e;

  // Distance from midscale; the single 2048 case (sample 0) clamps to 2047.
  function automatic logic [MAG_W-1:0] sample_mag(input logic [SAMPLE_W-1:0] s);
    logic [SAMPLE_W-1:0] d;
    if (s >= SAMPLE_W'(MIDSCALE)) d = s - SAMPLE_W'(MIDSCALE);
    else                          d = SAMPLE_W'(MIDSCALE) - s;
    return d[SAMPLE_W-1] ? {MAG_W{1'b1}} : d[MAG_W-1:0];
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Push-button debouncer: accepts a level change after DEBOUNCE_CYCLES stable
// cycles and emits a one-cycle press pulse on each accepted 0->1 change.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic CLOCK,
  input  logic RESET,
  input  logic raw,
  output logic press
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             stable_q, stable_d;
  logic             stable_dly_q;
  logic             press_q;

  always_comb begin
    cnt_d    = '0;
    stable_d = stable_q;
    if (raw != stable_q) begin
      if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) stable_d = ~stable_q;
      else                                      cnt_d    = cnt_q + 1'b1;
    end
  end

  // NOTE: non-blocking assignments so every flop samples pre-edge values,
  // which is what makes stable_dly_q lag stable_q by exactly one cycle.
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      cnt_q        <= '0;
      stable_q     <= 1'b0;
      stable_dly_q <= 1'b0;
      press_q      <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      stable_q     <= stable_d;
      stable_dly_q <= stable_q;
      press_q      <= stable_q & ~stable_dly_q;
    end
  end

  assign press = press_q;

endmodule

// File: rtl/display_mode_ctrl.sv
// Button-driven display mode FSM, mic peak/volume meter and OLED redraw
// handshake. Define DISPLAY_MODE_CTRL_PEAK_DECAY_EN for peak-hold level decay.
module display_mode_ctrl
  import display_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int PEAK_WINDOW     = 2000
) (
  input  logic                CLOCK,
  input  logic                RESET,
  input  logic                btn_c,
  input  logic                btn_u,
  input  logic                btn_d,
  input  logic                btn_l,
  input  logic                btn_r,
  input  logic                sample_valid,
  input  logic [SAMPLE_W-1:0] sample,
  input  logic                redraw_ack,
  output logic [MODE_W-1:0]   mode,
  output logic [GAIN_W-1:0]   gain,
  output logic [LEVEL_W-1:0]  vol_level,
  output logic [LED_W-1:0]    led_bar,
  output logic                redraw_req
);

  localparam int WIN_W = $clog2(PEAK_WINDOW + 1);
  localparam logic [LEVEL_W-1:0] LEVEL_MAX = {LEVEL_W{1'b1}};

  logic [NUM_BTN-1:0] raw_btn, press;
  assign raw_btn = {btn_d, btn_u, btn_l, btn_r, btn_c};

  for (genvar b = 0; b < NUM_BTN; b++) begin : g_btn
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
      .CLOCK(CLOCK), .RESET(RESET), .raw(raw_btn[b]), .press(press[b])
    );
  end

  mode_e              mode_q, mode_d, saved_q, saved_d, mode_prev_q;
  logic [GAIN_W-1:0]  gain_q, gain_d;
  logic               req_q, req_d, mode_changed;
  logic [MAG_W-1:0]   peak_q, peak_d, mag, peak_max;
  logic [WIN_W-1:0]   win_q, win_d;
  logic [SCALED_W-1:0] scaled;
  logic [LEVEL_W-1:0] new_level, vol_q, vol_d;
  logic [LED_W-1:0]   led_q, led_d;

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      mode_q  <= IDLE;
      saved_q <= IDLE;
      gain_q  <= '0;
    end else begin
      mode_q  <= mode_d;
      saved_q <= saved_d;
      gain_q  <= gain_d;
    end
  end

  // NOTE: every comb output gets a default first so no latch is inferred.
  always_comb begin
    mode_d  = mode_q;
    saved_d = saved_q;
    gain_d  = gain_q;
    if (press[BTN_C]) begin
      if (mode_q == MENU) begin
        mode_d = saved_q;
      end else begin
        saved_d = mode_q;
        mode_d  = MENU;
      end
    end else if (press[BTN_R]) begin
      if (mode_q != MENU) mode_d = (mode_q == WAVE) ? IDLE : mode_e'(mode_q + 2'd1);
    end else if (press[BTN_L]) begin
      if (mode_q != MENU) mode_d = (mode_q == IDLE) ? WAVE : mode_e'(mode_q - 2'd1);
    end else if (press[BTN_U]) begin
      if (mode_q == MENU && gain_q != GAIN_W'(GAIN_MAX)) gain_d = gain_q + 1'b1;
    end else if (press[BTN_D]) begin
      if (mode_q == MENU && gain_q != '0) gain_d = gain_q - 1'b1;
    end
  end

  always_comb begin
    mode       = mode_q;
    gain       = gain_q;
    vol_level  = vol_q;
    led_bar    = led_q;
    redraw_req = req_q;
  end

  // The cycle where mode_q first shows a new value raises the request next;
  // a fresh change outranks an ack seen in the same cycle.
  assign mode_changed = (mode_q != mode_prev_q);
  assign req_d        = mode_changed | (req_q & ~redraw_ack);

  always_comb begin
    mag       = sample_mag(sample);
    peak_max  = (mag > peak_q) ? mag : peak_q;
    scaled    = (SCALED_W'(peak_max) << gain_q) >> 7;
    new_level = (scaled > SCALED_W'(LEVEL_MAX)) ? LEVEL_MAX : scaled[LEVEL_W-1:0];
    peak_d    = peak_q;
    win_d     = win_q;
    vol_d     = vol_q;
    if (sample_valid) begin
      if (win_q == WIN_W'(PEAK_WINDOW - 1)) begin
        peak_d = '0;
        win_d  = '0;
`ifdef DISPLAY_MODE_CTRL_PEAK_DECAY_EN
        vol_d  = (new_level >= vol_q) ? new_level : vol_q - 1'b1;
`else
        vol_d  = new_level;
`endif
      end else begin
        peak_d = peak_max;
        win_d  = win_q + 1'b1;
      end
    end
    for (int i = 0; i < LED_W; i++) led_d[i] = (5'(i) < {1'b0, vol_d});
  end

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      mode_prev_q <= IDLE;
      req_q       <= 1'b0;
      peak_q      <= '0;
      win_q       <= '0;
      vol_q       <= '0;
      led_q       <= '0;
    end else begin
      mode_prev_q <= mode_q;
      req_q       <= req_d;
      peak_q      <= peak_d;
      win_q       <= win_d;
      vol_q       <= vol_d;
      led_q       <= led_d;
    end
  end

endmodule

// File: tb/tb_display_mode_ctrl.sv
// Directed bench for display_mode_ctrl with DEBOUNCE_CYCLES=4, PEAK_WINDOW=8.
module tb_display_mode_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [4:0]  btns = '0;   // {d, u, l, r, c}
  logic        sample_valid = 1'b0;
  logic [11:0] sample = 12'd2048;
  logic        redraw_ack = 1'b0;
  logic [1:0]  mode;
  logic [2:0]  gain;
  logic [3:0]  vol_level;
  logic [15:0] led_bar;
  logic        redraw_req;

  int vectors = 0;
  int miscompares = 0;

  localparam int C = 0, R = 1, L = 2, U = 3, D = 4;

  always #5 clk = ~clk;

  display_mode_ctrl #(.DEBOUNCE_CYCLES(4), .PEAK_WINDOW(8)) dut (
    .CLOCK(clk), .RESET(rst),
    .btn_c(btns[0]), .btn_r(btns[1]), .btn_l(btns[2]), .btn_u(btns[3]), .btn_d(btns[4]),
    .sample_valid(sample_valid), .sample(sample), .redraw_ack(redraw_ack),
    .mode(mode), .gain(gain), .vol_level(vol_level), .led_bar(led_bar),
    .redraw_req(redraw_req)
  );

  task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic press_btn(input int idx);
    btns[idx] = 1'b1;
    repeat (10) tick();
    btns[idx] = 1'b0;
    repeat (10) tick();
  endtask

  task automatic ack_once();
    redraw_ack = 1'b1;
    tick();
    redraw_ack = 1'b0;
  endtask

  task automatic send_sample(input logic [11:0] s);
    sample = s;
    sample_valid = 1'b1;
    tick();
    sample_valid = 1'b0;
    sample = 12'd2048;
    tick();
  endtask

  function automatic logic [15:0] therm(input int lvl);
    logic [15:0] r = '0;
    for (int i = 0; i < lvl; i++) r[i] = 1'b1;
    return r;
  endfunction

  // One full window: s0 first, then seven midscale samples.
  task automatic run_window(input logic [11:0] s0, input int exp_level, input string tag);
    send_sample(s0);
    repeat (6) send_sample(12'd2048);
    sample = 12'd2048;
    sample_valid = 1'b1;
    tick();
    sample_valid = 1'b0;
    check(tag, vol_level, exp_level);
    check({tag, "_led"}, led_bar, therm(exp_level));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
  endtask

  initial begin
    bit seen;
    // Reset state
    repeat (2) tick();
    check("rst_mode", mode, 0);
    check("rst_gain", gain, 0);
    check("rst_vol", vol_level, 0);
    check("rst_led", led_bar, 0);
    check("rst_req", redraw_req, 0);
    rst = 1'b0;
    tick();

    // Debounce latency: pulse five edges after the raw edge, mode the edge after
    btns[R] = 1'b1;
    repeat (5) tick();
    check("deb_early_mode", mode, 0);
    tick();
    check("deb_mode", mode, 1);
    check("deb_req_early", redraw_req, 0);
    tick();
    check("deb_req", redraw_req, 1);
    repeat (3) tick();
    btns[R] = 1'b0;
    repeat (10) tick();
    check("deb_single_pulse", mode, 1);
    ack_once();
    check("ack_clears", redraw_req, 0);

    // R wraps forward, L wraps back, glitch ignored
    press_btn(R);
    check("r_to_wave", mode, 2);
    press_btn(R);
    check("r_wrap_idle", mode, 0);
    press_btn(L);
    check("l_wrap_wave", mode, 2);
    btns[L] = 1'b1;
    repeat (2) tick();
    btns[L] = 1'b0;
    repeat (10) tick();
    check("glitch_ignored", mode, 2);

    // Menu and gain saturation
    press_btn(C);
    check("c_enter_menu", mode, 3);
    repeat (9) press_btn(U);
    check("gain_sat_hi", gain, 7);
    repeat (2) press_btn(D);
    check("gain_down", gain, 5);
    press_btn(R);
    check("r_in_menu_ignored", mode, 3);
    press_btn(C);
    check("c_restore", mode, 2);
    press_btn(U);
    check("u_outside_ignored", gain, 5);

    // Simultaneous C and R: C wins
    btns[C] = 1'b1;
    btns[R] = 1'b1;
    repeat (10) tick();
    btns = '0;
    repeat (10) tick();
    check("c_beats_r", mode, 3);
    press_btn(C);
    check("c_r_restore", mode, 2);

    // Peak measurement at gain 0
    do_reset();
    check("rst2_gain", gain, 0);
    send_sample(12'd2048);
    send_sample(12'd3000);
    send_sample(12'd1000);
    repeat (4) send_sample(12'd2048);
    sample = 12'd2048;
    sample_valid = 1'b1;
    check("win_pre_close", vol_level, 0);
    tick();
    sample_valid = 1'b0;
    check("win_level8", vol_level, 8);
    check("win_led8", led_bar, 16'h00FF);

    // Level 12 then quiet windows
    run_window(12'd3648, 12, "lvl12");
`ifdef DISPLAY_MODE_CTRL_PEAK_DECAY_EN
    run_window(12'd2048, 11, "decay1");
    run_window(12'd2048, 10, "decay2");
    run_window(12'd2048, 9, "decay3");
`else
    run_window(12'd2048, 0, "quiet1");
    run_window(12'd2048, 0, "quiet2");
`endif

    // Gain 3 with full-scale sample clamps to 15
    press_btn(C);
    repeat (3) press_btn(U);
    press_btn(C);
    check("gain3", gain, 3);
    check("gain3_mode", mode, 0);
    run_window(12'd0, 15, "clamp15");
    check("clamp15_bar", led_bar, 16'h7FFF);

    // Handshake: ack with nothing pending, coalescing, change-in-ack-cycle
    ack_once();
    check("hs_clear", redraw_req, 0);
    ack_once();
    check("hs_idle_ack", redraw_req, 0);
    press_btn(R);
    press_btn(R);
    check("hs_two_changes", mode, 2);
    check("hs_pending", redraw_req, 1);
    ack_once();
    check("hs_one_ack", redraw_req, 0);
    repeat (5) tick();
    check("hs_coalesced", redraw_req, 0);
    press_btn(R);
    check("hs_pend_again", redraw_req, 1);
    btns[R] = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      tick();
      if (mode != 0) seen = 1'b1;
    end
    check("hs_poll_timeout", seen, 1);
    redraw_ack = 1'b1;
    tick();
    redraw_ack = 1'b0;
    check("hs_change_beats_ack", redraw_req, 1);
    btns[R] = 1'b0;
    repeat (10) tick();
    ack_once();
    check("hs_final_clear", redraw_req, 0);

    // Async reset mid-window with request pending
    press_btn(R);
    check("mid_req", redraw_req, 1);
    repeat (4) send_sample(12'd0);
    #2 rst = 1'b1;
    #1;
    check("arst_mode", mode, 0);
    check("arst_gain", gain, 0);
    check("arst_vol", vol_level, 0);
    check("arst_led", led_bar, 0);
    check("arst_req", redraw_req, 0);
    #2 rst = 1'b0;
    tick();
    send_sample(12'd3648);
    repeat (6) send_sample(12'd2048);
    check("post_rst_no_early_close", vol_level, 0);
    sample_valid = 1'b1;
    tick();
    sample_valid = 1'b0;
    check("post_rst_window", vol_level, 12);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
